// File: rtl/sdp_ram_be_pipe_if.sv
// Bus bundle for the byte-enabled simple-dual-port tile buffer.
// The master drives write/read requests; the slave (the RAM) returns read
// results, their valid strobe and the sticky out-of-range flag.
interface sdp_ram_be_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9
);
    localparam int NB = DATA_W / 8;

    // Write port
    logic              wr_en;
    logic [NB-1:0]     wr_be;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Read request
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    // Read response and status
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              oob_err;

    modport master (
        output wr_en, wr_be, wr_addr, wr_data,
        output rd_en, rd_addr,
        input  rd_data, rd_valid, oob_err
    );

    modport slave (
        input  wr_en, wr_be, wr_addr, wr_data,
        input  rd_en, rd_addr,
        output rd_data, rd_valid, oob_err
    );
endinterface

// File: rtl/sdp_ram_be_pipe.sv
// Simple-dual-port RAM with per-byte write enables and a pipelined read port.
// Read results emerge RD_LAT cycles after the request with a one-cycle valid
// pulse; same-address read/write collisions return either the old word or a
// per-byte merge with the incoming write, selected by RDW_MODE. Requests with
// an address >= DEPTH are dropped (writes) or return zero (reads) and latch
// a sticky error flag that only reset clears. Array contents survive reset.
module sdp_ram_be_pipe #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 512,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int RD_LAT   = 2,
    parameter int RDW_MODE = 0
) (
    input  logic             clka,
    input  logic             rst,
    sdp_ram_be_pipe_if.slave bus
);

    localparam int NB = DATA_W / 8;

    // DEPTH held one bit wider than an address so the range compare never truncates.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    // Elaboration-time parameter legality
    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
        $error("sdp_ram_be_pipe: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sdp_ram_be_pipe: DEPTH must be at least 2");
    end
    if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr
        $error("sdp_ram_be_pipe: ADDR_W is derived from DEPTH and must not be overridden");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("sdp_ram_be_pipe: RD_LAT must be in 1..4");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_mode
        $error("sdp_ram_be_pipe: RDW_MODE must be 0 or 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_fire;
    logic              collide;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] pipe_data [RD_LAT];
    logic              pipe_vld  [RD_LAT];
    logic              oob_q;

    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_C);
    assign wr_fire     = bus.wr_en && wr_in_range;
    assign collide     = bus.wr_en && bus.rd_en && wr_in_range && rd_in_range
                         && (bus.wr_addr == bus.rd_addr);

    // Byte-lane write; reset blocks writes but never clears the array.
    always_ff @(posedge clka) begin
        if (!rst && wr_fire) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.wr_be[i]) begin
                    mem[bus.wr_addr][i*8 +: 8] <= bus.wr_data[i*8 +: 8];
                end
            end
        end
    end

    // Word entering the read pipe: zero when out of range, old contents
    // otherwise, with write-first lanes overlaid on a collision when enabled.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.rd_addr];
            if (RDW_MODE == 1 && collide) begin
                for (int unsigned i = 0; i < NB; i++) begin
                    if (bus.wr_be[i]) begin
                        rd_word[i*8 +: 8] = bus.wr_data[i*8 +: 8];
                    end
                end
            end
        end
    end

    // Pipe stage 0 captures the addressed word at the request edge, so later
    // writes to the same address cannot disturb an in-flight result.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            pipe_vld[0]  <= 1'b0;
            pipe_data[0] <= '0;
        end else begin
            pipe_vld[0] <= bus.rd_en;
            if (bus.rd_en) begin
                pipe_data[0] <= rd_word;
            end
        end
    end

    // Later stages advance data only alongside a valid bit, so the last stage
    // (the visible rd_data) holds its value between results.
    for (genvar k = 1; k < RD_LAT; k++) begin : g_stage
        // Shift one stage of the read pipeline
        always_ff @(posedge clka or posedge rst) begin
            if (rst) begin
                pipe_vld[k]  <= 1'b0;
                pipe_data[k] <= '0;
            end else begin
                pipe_vld[k] <= pipe_vld[k-1];
                if (pipe_vld[k-1]) begin
                    pipe_data[k] <= pipe_data[k-1];
                end
            end
        end
    end

    // Sticky out-of-range flag for any enabled request
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            oob_q <= 1'b0;
        end else if ((bus.wr_en && !wr_in_range) || (bus.rd_en && !rd_in_range)) begin
            oob_q <= 1'b1;
        end
    end

    assign bus.rd_data  = pipe_data[RD_LAT-1];
    assign bus.rd_valid = pipe_vld[RD_LAT-1];
    assign bus.oob_err  = oob_q;

endmodule

// File: tb/tb_sdp_ram_be_pipe.sv
// Scoreboard bench for sdp_ram_be_pipe: four instances (RD_LAT 1..4,
// alternating read-during-write mode, DEPTH=500) share one directed stimulus
// stream; expected read words are queued per instance at issue time and
// popped by a monitor whenever that instance pulses rd_valid.
module tb_sdp_ram_be_pipe;

    localparam int DW    = 64;
    localparam int DEPTH = 500;
    localparam int AW    = 9;
    localparam int NI    = 4;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    logic          wr_en   = 1'b0;
    logic [7:0]    wr_be   = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en   = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic          rdv [NI];
    logic [DW-1:0] rdd [NI];
    logic          oob [NI];

    logic [DW-1:0] expq [NI][$];
    logic [DW-1:0] last [NI];
    logic          exp_oob = 1'b0;
    logic          done    = 1'b0;
    int            errors  = 0;
    int            checks  = 0;

    // Instance g: RD_LAT = g+1, RDW_MODE = 1 for even g (write-first), 0 for odd g
    for (genvar g = 0; g < NI; g++) begin : g_dut
        sdp_ram_be_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.wr_en   = wr_en;
        assign bus.wr_be   = wr_be;
        assign bus.wr_addr = wr_addr;
        assign bus.wr_data = wr_data;
        assign bus.rd_en   = rd_en;
        assign bus.rd_addr = rd_addr;
        assign rdv[g] = bus.rd_valid;
        assign rdd[g] = bus.rd_data;
        assign oob[g] = bus.oob_err;

        sdp_ram_be_pipe #(
            .DATA_W  (DW),
            .DEPTH   (DEPTH),
            .RD_LAT  (g + 1),
            .RDW_MODE((g % 2 == 0) ? 1 : 0)
        ) dut (
            .clka(clka),
            .rst (rst),
            .bus (bus)
        );
    end

    task automatic chk(input string name, input int g, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, g, act, exp);
        end
    endtask

    // Monitor: reset values, sticky flag, scoreboard pops and rd_data hold
    always @(negedge clka) begin
        for (int g = 0; g < NI; g++) begin
            if (rst) begin
                expq[g].delete();
                last[g] = '0;
                chk("reset_valid", g, DW'(rdv[g]), '0);
                chk("reset_data", g, rdd[g], '0);
                chk("reset_oob", g, DW'(oob[g]), '0);
            end else begin
                chk("oob_err", g, DW'(oob[g]), DW'(exp_oob));
                if (rdv[g] === 1'b1) begin
                    if (expq[g].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid dut%0d: got rd_valid=1 with data %h expected no result", g, rdd[g]);
                    end else begin
                        last[g] = expq[g].pop_front();
                        chk("rd_data", g, rdd[g], last[g]);
                    end
                end else begin
                    chk("rd_hold", g, rdd[g], last[g]);
                end
            end
        end
        if (done) begin
            for (int g = 0; g < NI; g++) begin
                chk("pending", g, DW'(expq[g].size()), '0);
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clka);
        #1;
    endtask

    // One clock of stimulus; e0/e1 are the expected read words for read-first / write-first instances
    task automatic op(input logic we, input int wa, input logic [DW-1:0] wd, input logic [7:0] be,
                      input logic re, input int ra, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = AW'(ra);
        if (re) begin
            for (int g = 0; g < NI; g++) begin
                expq[g].push_back((g % 2 == 0) ? e1 : e0);
            end
        end
        cyc(1);
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_be = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [7:0] be);
        op(1'b1, a, d, be, 1'b0, 0, '0, '0);
    endtask

    task automatic rd(input int a, input logic [DW-1:0] e);
        op(1'b0, 0, '0, '0, 1'b1, a, e, e);
    endtask

    initial begin
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Full write then read back next cycle
        wr(5, 64'h0123456789ABCDEF, 8'hFF);
        rd(5, 64'h0123456789ABCDEF);
        // Low-half partial write
        wr(5, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
        rd(5, 64'h01234567FFFFFFFF);
        // be=0 write colliding with a read is a no-op in both modes
        op(1'b1, 5, 64'hDEADBEEFDEADBEEF, 8'h00, 1'b1, 5, 64'h01234567FFFFFFFF, 64'h01234567FFFFFFFF);
        rd(5, 64'h01234567FFFFFFFF);

        // Same-cycle collision, upper-lane write
        wr(9, 64'h1111111111111111, 8'hFF);
        op(1'b1, 9, 64'h2222222222222222, 8'hF0, 1'b1, 9, 64'h1111111111111111, 64'h2222222211111111);
        rd(9, 64'h2222222211111111);

        // Write landing after the read was sampled does not alter it
        rd(5, 64'h01234567FFFFFFFF);
        wr(5, 64'hAAAAAAAAAAAAAAAA, 8'hFF);
        rd(5, 64'hAAAAAAAAAAAAAAAA);

        // Last in-range address
        wr(499, 64'h0F0F0F0F0F0F0F0F, 8'hFF);
        rd(499, 64'h0F0F0F0F0F0F0F0F);
        cyc(4);

        // Out-of-range write, then out-of-range reads
        wr(510, 64'h5555555555555555, 8'hFF);
        exp_oob = 1'b1;
        rd(510, 64'h0);
        rd(500, 64'h0);
        rd(5, 64'hAAAAAAAAAAAAAAAA);
        rd(499, 64'h0F0F0F0F0F0F0F0F);
        cyc(4);

        // Back-to-back reads cut off by a one-cycle reset
        wr(0, 64'h1000000000000001, 8'hFF);
        wr(1, 64'h2000000000000002, 8'hFF);
        wr(2, 64'h3000000000000003, 8'hFF);
        wr(3, 64'h4000000000000004, 8'hFF);
        rd(0, 64'h1000000000000001);
        rd(1, 64'h2000000000000002);
        rd(2, 64'h3000000000000003);
        rd(3, 64'h4000000000000004);
        cyc(1);
        rst     = 1'b1;
        exp_oob = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(6);

        // Contents retained across reset; back-to-back results in order
        rd(0, 64'h1000000000000001);
        rd(1, 64'h2000000000000002);
        rd(2, 64'h3000000000000003);
        op(1'b1, 3, 64'h00000000000000EE, 8'h01, 1'b1, 3, 64'h4000000000000004, 64'h40000000000000EE);
        rd(3, 64'h40000000000000EE);
        cyc(8);
        done = 1'b1;
    end

endmodule
